ram_1r1w_sync_pipe: RTL and testbench
=====================================

// Module: ram_1r1w_sync_pipe
// PURPOSE
//  Parametrised 1R1W synchronous RAM for line/frame buffering in the vision pipeline.
//  Adds over plain sync RAM:
//   - per-bit write mask
//   - configurable write->read forwarding
//   - optional output pipeline stage with rd_valid_o
//   - post-reset hardware clear sweep with ready/busy handshake
//  Sits between the camera/filter stages and line-buffer control logic.
// PARAMETERS
//  width_p      8    data word width in bits (>=1)
//  depth_p      512  number of words (>=2); address width aw = $clog2(depth_p)
//  bypass_p     1    1: same-cycle same-address read returns newly written bits; 0: returns old word
//  out_reg_p    0    0: read latency 1; 1: extra output register, read latency 2
//  init_clear_p 1    1: zero all words after reset; 0: contents undefined after reset
// PORTS
//  clk_i       in   1        clock, all logic on rising edge
//  reset_ni    in   1        asynchronous, active-low reset
//  wr_valid_i  in   1        write request
//  wr_ready_o  out  1        write accepted when wr_valid_i & wr_ready_o
//  wr_addr_i   in   aw       write address
//  wr_data_i   in   width_p  write data
//  wr_mask_i   in   width_p  per-bit enable; 1 = bit written
//  rd_valid_i  in   1        read request
//  rd_ready_o  out  1        read accepted when rd_valid_i & rd_ready_o
//  rd_addr_i   in   aw       read address
//  rd_valid_o  out  1        rd_data_o carries result of an accepted read this cycle
//  rd_data_o   out  width_p  read data; holds last value when rd_valid_o=0
//  rd_perr_o   out  1        parity error, aligned with rd_valid_o
//  busy_o      out  1        clear sweep in progress
// BEHAVIOUR
//  Reset (async assert, sync deassert handled upstream):
//   - rd_valid_o=0, rd_data_o=0, rd_perr_o=0
//   - clear counter=0
//   - state=CLEAR if init_clear_p else READY
//   - memory array itself is not reset
//  FSM:
//   - CLEAR: busy_o=1, wr_ready_o=rd_ready_o=0; writes 0 (parity 0) to addr cnt each cycle;
//     cnt==depth_p-1 -> READY. Sweep takes exactly depth_p cycles after reset release.
//   - READY: busy_o=0, wr_ready_o=rd_ready_o=1; stays until reset.
//   - Reset during CLEAR restarts sweep at address 0.
//  Write (accepted): mem[a] <= (mem[a] & ~wr_mask_i) | (wr_data_i & wr_mask_i); mask 0 = no change.
//  Read (accepted):
//   - rd_valid_o asserts exactly 1+out_reg_p cycles later, for one cycle per read.
//   - Back-to-back reads every cycle give one result per cycle.
//  Collision (accepted read+write, same address, same cycle):
//   - bypass_p=1: result = (old & ~mask) | (new & mask).
//   - bypass_p=0: result = old word. Memory updated in both cases.
//   - Different addresses: independent.
//  Addresses >= depth_p (non-power-of-2 depth): write ignored, read returns 0.
//  Requests while not ready are dropped, never queued.
// CONFIGURATION
//  RAM_PARITY_EN defined:
//   - each word stores an extra even-parity bit of the stored (merged) word.
//   - on read, rd_perr_o=1 when recomputed parity != stored; aligned with rd_valid_o.
//   - bypassed collision reads use freshly computed parity (never flag).
//  RAM_PARITY_EN undefined: no parity storage; rd_perr_o tied 0.
// TESTING
//  1. Reset release, init_clear_p=1, depth_p=512
//     -> busy_o=1 for 512 cycles, ready outputs 0, then 1; read any addr -> 0.
//  2. Write 0xA5 @3, read @3 next cycle
//     -> rd_valid_o 1 cycle after accept (2 with out_reg_p=1), rd_data_o=0xA5.
//  3. mem[7]=0xFF; write 0x00 mask 0x0F @7
//     -> read @7 returns 0xF0.
//  4. mem[9]=0x11; same-cycle write 0x22 mask 0xFF + read @9
//     -> bypass_p=1: 0x22; bypass_p=0: 0x11; later read 0x22.
//  5. Reset mid-sweep (cycle 100)
//     -> counter restarts; busy_o lasts full 512 cycles after release; no request accepted while busy.
//  6. RAM_PARITY_EN: bench flips stored parity bit of addr 5 via hierarchy
//     -> read @5: rd_perr_o=1 with rd_valid_o; read @6: rd_perr_o=0.

Source files
------------

// File: rtl/ram_1r1w_sync_pipe_if.sv
// Bus bundle for ram_1r1w_sync_pipe: one write port, one read port,
// read response and status. The RAM uses the slave modport; the client
// that issues requests uses the master modport.
//
// Handshake: a request on either port is accepted on a rising clock edge
// where its *_valid_i and the matching *_ready_o are both high. Valid may
// be raised without waiting for ready, and a request that is not accepted
// is dropped, not held or queued. rd_valid_o pulses for one cycle per
// accepted read; there is no backpressure on the response.
interface ram_1r1w_sync_pipe_if #(
  parameter int width_p = 8,
  parameter int aw_p    = 9
);
  logic               wr_valid_i;
  logic               wr_ready_o;
  logic [aw_p-1:0]    wr_addr_i;
  logic [width_p-1:0] wr_data_i;
  logic [width_p-1:0] wr_mask_i;
  logic               rd_valid_i;
  logic               rd_ready_o;
  logic [aw_p-1:0]    rd_addr_i;
  logic               rd_valid_o;
  logic [width_p-1:0] rd_data_o;
  logic               rd_perr_o;
  logic               busy_o;
  // Controller state for observation: 0 = clear sweep, 1 = ready.
  logic               state_dbg;

  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i, wr_mask_i, rd_valid_i, rd_addr_i,
    input  wr_ready_o, rd_ready_o, rd_valid_o, rd_data_o, rd_perr_o, busy_o,
           state_dbg
  );

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i, wr_mask_i, rd_valid_i, rd_addr_i,
    output wr_ready_o, rd_ready_o, rd_valid_o, rd_data_o, rd_perr_o, busy_o,
           state_dbg
  );
endinterface

// File: rtl/ram_1r1w_sync_pipe.sv
// ram_1r1w_sync_pipe: 1R1W synchronous RAM for line/frame buffering.
// Features: per-bit write mask, optional write->read forwarding on a
// same-address collision, optional extra output register, and a hardware
// clear sweep after reset with busy/ready status.
// Optional feature macro: RAM_PARITY_EN adds one even-parity bit per word
// and reports parity errors on rd_perr_o; without it rd_perr_o is 0.
module ram_1r1w_sync_pipe #(
  parameter int width_p      = 8,
  parameter int depth_p      = 512,
  parameter int bypass_p     = 1,
  parameter int out_reg_p    = 0,
  parameter int init_clear_p = 1
) (
  input logic                   clk_i,
  input logic                   reset_ni,
  ram_1r1w_sync_pipe_if.slave   bus
);

  localparam int aw = (depth_p > 1) ? $clog2(depth_p) : 1;
`ifdef RAM_PARITY_EN
  localparam int mw = width_p + 1;
`else
  localparam int mw = width_p;
`endif

  typedef enum logic {
    st_clear = 1'b0,
    st_ready = 1'b1
  } state_t;

  state_t          state_q;
  logic [aw-1:0]   cnt_q;
  logic            busy_q;
  logic            ready_q;

  // Storage word: data in the low bits, parity (when enabled) on top.
  logic [mw-1:0]   mem [depth_p];

  logic               wr_fire;
  logic               rd_fire;
  logic               wr_in_range;
  logic               rd_in_range;
  logic               collide;
  logic [width_p-1:0] wr_merged;
  logic [mw-1:0]      wr_word;
  logic [mw-1:0]      rd_word;
  logic [width_p-1:0] rd_data_n;
  logic               rd_perr_n;

  logic               v1_q;
  logic [width_p-1:0] d1_q;
  logic               p1_q;

  // Controller: sweep every address once after reset, then serve requests forever.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= (init_clear_p != 0) ? st_clear : st_ready;
      cnt_q   <= '0;
      busy_q  <= (init_clear_p != 0);
      ready_q <= (init_clear_p == 0);
    end else begin
      case (state_q)
        st_clear: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == aw'(depth_p - 1)) begin
            state_q <= st_ready;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        st_ready: begin
          state_q <= st_ready;
        end
        default: begin
          state_q <= st_ready;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign wr_fire     = bus.wr_valid_i & ready_q;
  assign rd_fire     = bus.rd_valid_i & ready_q;
  // Non-power-of-two depths leave a hole at the top of the address space.
  assign wr_in_range = ({1'b0, bus.wr_addr_i} < (aw + 1)'(depth_p));
  assign rd_in_range = ({1'b0, bus.rd_addr_i} < (aw + 1)'(depth_p));
  assign collide     = wr_fire & wr_in_range & (bus.wr_addr_i == bus.rd_addr_i);

  // Masked write is a read-modify-write of the addressed word.
  assign wr_merged = (mem[bus.wr_addr_i][width_p-1:0] & ~bus.wr_mask_i) |
                     (bus.wr_data_i & bus.wr_mask_i);
`ifdef RAM_PARITY_EN
  assign wr_word = {^wr_merged, wr_merged};
`else
  assign wr_word = wr_merged;
`endif

  assign rd_word = mem[bus.rd_addr_i];

  // Memory update: sweep zeros while clearing, otherwise accepted in-range writes.
  always_ff @(posedge clk_i) begin
    if (state_q == st_clear) begin
      mem[cnt_q] <= '0;
    end else if (wr_fire && wr_in_range) begin
      mem[bus.wr_addr_i] <= wr_word;
    end
  end

  // Read result selection: stored word, forwarded merge on collision, or 0 out of range.
  always_comb begin
    rd_data_n = rd_word[width_p-1:0];
`ifdef RAM_PARITY_EN
    rd_perr_n = (^rd_word[width_p-1:0]) != rd_word[width_p];
`else
    rd_perr_n = 1'b0;
`endif
    if (collide && (bypass_p != 0)) begin
      // Forwarded data never went through storage, so it cannot carry an error.
      rd_data_n = wr_merged;
      rd_perr_n = 1'b0;
    end
    if (!rd_in_range) begin
      rd_data_n = '0;
      rd_perr_n = 1'b0;
    end
  end

  // First read stage: data holds between reads, valid/perr pulse per read.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      v1_q <= 1'b0;
      d1_q <= '0;
      p1_q <= 1'b0;
    end else begin
      v1_q <= rd_fire;
      p1_q <= rd_fire & rd_perr_n;
      if (rd_fire) begin
        d1_q <= rd_data_n;
      end
    end
  end

  if (out_reg_p != 0) begin : g_out_reg
    logic               v2_q;
    logic [width_p-1:0] d2_q;
    logic               p2_q;

    // Optional output register: same hold/pulse behaviour one cycle later.
    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        v2_q <= 1'b0;
        d2_q <= '0;
        p2_q <= 1'b0;
      end else begin
        v2_q <= v1_q;
        p2_q <= v1_q & p1_q;
        if (v1_q) begin
          d2_q <= d1_q;
        end
      end
    end

    assign bus.rd_valid_o = v2_q;
    assign bus.rd_data_o  = d2_q;
    assign bus.rd_perr_o  = p2_q;
  end else begin : g_no_out_reg
    assign bus.rd_valid_o = v1_q;
    assign bus.rd_data_o  = d1_q;
    assign bus.rd_perr_o  = p1_q;
  end

  assign bus.wr_ready_o = ready_q;
  assign bus.rd_ready_o = ready_q;
  assign bus.busy_o     = busy_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_ram_1r1w_sync_pipe.sv
// Directed testbench for ram_1r1w_sync_pipe (default parameters).
module tb_ram_1r1w_sync_pipe;

  localparam int W        = 8;
  localparam int AW       = 9;
  localparam int DEPTH    = 512;
  localparam int BYPASS   = 1;
  localparam int OUT_REG  = 0;
  localparam int LAT      = 1 + OUT_REG;
  localparam int MAX_WAIT = 2000;

  logic clk_i;
  logic reset_ni;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];

  ram_1r1w_sync_pipe_if #(.width_p(W), .aw_p(AW)) bus ();

  ram_1r1w_sync_pipe #(
    .width_p(W), .depth_p(DEPTH), .bypass_p(BYPASS),
    .out_reg_p(OUT_REG), .init_clear_p(1)
  ) dut (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .bus     (bus)
  );

  // Clock and watchdog
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: one request cycle (write and/or read), then wait out the read latency.
  task automatic access(input logic wv, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                        input logic [W-1:0] wm, input logic rv, input logic [AW-1:0] ra,
                        output logic v, output logic [W-1:0] d, output logic p,
                        output logic early);
    bus.wr_valid_i = wv;
    bus.wr_addr_i  = wa;
    bus.wr_data_i  = wd;
    bus.wr_mask_i  = wm;
    bus.rd_valid_i = rv;
    bus.rd_addr_i  = ra;
    early = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk_i); #1;
      if (k == 1) begin
        bus.wr_valid_i = 1'b0;
        bus.rd_valid_i = 1'b0;
      end
      if (k < LAT && bus.rd_valid_o) early = 1'b1;
    end
    v = bus.rd_valid_o;
    d = bus.rd_data_o;
    p = bus.rd_perr_o;
  endtask

  task automatic idle_inputs();
    bus.wr_valid_i = 1'b0;
    bus.wr_addr_i  = '0;
    bus.wr_data_i  = '0;
    bus.wr_mask_i  = '0;
    bus.rd_valid_i = 1'b0;
    bus.rd_addr_i  = '0;
  endtask

  task automatic test_reset();
    int cycles;
    int viol;
    logic v, p, e;
    logic [W-1:0] d;
    idle_inputs();
    reset_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (bus.rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid_o); end
    checks++; if (bus.rd_data_o !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data_o); end
    checks++; if (bus.rd_perr_o !== 1'b0) begin errors++; $display("FAIL reset_rd_perr: got %b want 0", bus.rd_perr_o); end
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", bus.busy_o); end
    checks++; if (bus.wr_ready_o !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b want 0", bus.wr_ready_o); end
    checks++; if (bus.rd_ready_o !== 1'b0) begin errors++; $display("FAIL reset_rd_ready: got %b want 0", bus.rd_ready_o); end
    checks++; if (bus.state_dbg !== 1'b0) begin errors++; $display("FAIL reset_state: got %b want 0", bus.state_dbg); end
    reset_ni = 1'b1;
    cycles = 0;
    viol = 0;
    do begin
      @(posedge clk_i); #1;
      cycles++;
      if (bus.busy_o && (bus.wr_ready_o || bus.rd_ready_o)) viol++;
    end while (bus.busy_o && cycles < MAX_WAIT);
    checks++; if (cycles !== DEPTH) begin errors++; $display("FAIL sweep_length: got %0d want %0d", cycles, DEPTH); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL sweep_ready_low: got %0d violations want 0", viol); end
    checks++; if (bus.wr_ready_o !== 1'b1 || bus.rd_ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_sweep: got wr=%b rd=%b want 1 1", bus.wr_ready_o, bus.rd_ready_o); end
    access(1'b0, '0, '0, '0, 1'b1, 9'd0, v, d, p, e);
    checks++; if (v !== 1'b1 || d !== 8'h00) begin errors++; $display("FAIL cleared_addr0: got v=%b d=%h want v=1 d=00", v, d); end
    access(1'b0, '0, '0, '0, 1'b1, 9'd511, v, d, p, e);
    checks++; if (v !== 1'b1 || d !== 8'h00) begin errors++; $display("FAIL cleared_addr511: got v=%b d=%h want v=1 d=00", v, d); end
  endtask

  task automatic test_write_read();
    logic v, p, e;
    logic [W-1:0] d;
    access(1'b1, 9'd3, 8'hA5, 8'hFF, 1'b0, '0, v, d, p, e);
    access(1'b0, '0, '0, '0, 1'b1, 9'd3, v, d, p, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL read_latency_early: got early valid %b want 0", e); end
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL read_latency_valid: got %b want 1", v); end
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL read_a5: got %h want a5", d); end
    // One cycle later: valid drops, data holds.
    @(posedge clk_i); #1;
    checks++; if (bus.rd_valid_o !== 1'b0) begin errors++; $display("FAIL valid_single_pulse: got %b want 0", bus.rd_valid_o); end
    checks++; if (bus.rd_data_o !== 8'hA5) begin errors++; $display("FAIL data_hold: got %h want a5", bus.rd_data_o); end
  endtask

  task automatic test_mask();
    logic v, p, e;
    logic [W-1:0] d;
    access(1'b1, 9'd7, 8'hFF, 8'hFF, 1'b0, '0, v, d, p, e);
    access(1'b1, 9'd7, 8'h00, 8'h0F, 1'b0, '0, v, d, p, e);
    access(1'b0, '0, '0, '0, 1'b1, 9'd7, v, d, p, e);
    checks++; if (v !== 1'b1 || d !== 8'hF0) begin errors++; $display("FAIL mask_low_nibble: got v=%b d=%h want v=1 d=f0", v, d); end
    access(1'b1, 9'd7, 8'h12, 8'h00, 1'b0, '0, v, d, p, e);
    access(1'b0, '0, '0, '0, 1'b1, 9'd7, v, d, p, e);
    checks++; if (d !== 8'hF0) begin errors++; $display("FAIL mask_zero_nochange: got %h want f0", d); end
    access(1'b1, 9'd7, 8'h3C, 8'hAA, 1'b0, '0, v, d, p, e);
    access(1'b0, '0, '0, '0, 1'b1, 9'd7, v, d, p, e);
    // (f0 & 55) | (3c & aa) = 50 | 28 = 78
    checks++; if (d !== 8'h78) begin errors++; $display("FAIL mask_mixed: got %h want 78", d); end
  endtask

  task automatic test_collision();
    logic v, p, e;
    logic [W-1:0] d;
    logic [W-1:0] exp_full;
    logic [W-1:0] exp_part;
    access(1'b1, 9'd9, 8'h11, 8'hFF, 1'b0, '0, v, d, p, e);
    access(1'b1, 9'd9, 8'h22, 8'hFF, 1'b1, 9'd9, v, d, p, e);
    exp_full = (BYPASS != 0) ? 8'h22 : 8'h11;
    checks++; if (v !== 1'b1 || d !== exp_full) begin errors++; $display("FAIL collide_full: got v=%b d=%h want v=1 d=%h", v, d, exp_full); end
    access(1'b0, '0, '0, '0, 1'b1, 9'd9, v, d, p, e);
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL collide_mem_updated: got %h want 22", d); end
    // (22 & f0) | (5a & 0f) = 20 | 0a = 2a
    access(1'b1, 9'd9, 8'h5A, 8'h0F, 1'b1, 9'd9, v, d, p, e);
    exp_part = (BYPASS != 0) ? 8'h2A : 8'h22;
    checks++; if (d !== exp_part) begin errors++; $display("FAIL collide_partial: got %h want %h", d, exp_part); end
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL collide_perr: got %b want 0", p); end
    access(1'b0, '0, '0, '0, 1'b1, 9'd9, v, d, p, e);
    checks++; if (d !== 8'h2A) begin errors++; $display("FAIL collide_partial_mem: got %h want 2a", d); end
  endtask

  task automatic test_independent();
    logic v, p, e;
    logic [W-1:0] d;
    access(1'b1, 9'd10, 8'h33, 8'hFF, 1'b1, 9'd3, v, d, p, e);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL diff_addr_read: got %h want a5", d); end
    access(1'b0, '0, '0, '0, 1'b1, 9'd10, v, d, p, e);
    checks++; if (d !== 8'h33) begin errors++; $display("FAIL diff_addr_write: got %h want 33", d); end
  endtask

  task automatic test_back_to_back();
    logic v, p, e;
    logic [W-1:0] d;
    logic [W-1:0] exp_v;
    int got;
    for (int i = 0; i < 4; i++) begin
      access(1'b1, AW'(20 + i), W'(8'h40 + i), 8'hFF, 1'b0, '0, v, d, p, e);
    end
    got = 0;
    for (int c = 0; c < 4 + LAT; c++) begin
      bus.rd_valid_i = (c < 4);
      bus.rd_addr_i  = AW'(20 + c);
      if (c < 4) exp_q.push_back(W'(8'h40 + c));
      @(posedge clk_i); #1;
      if (bus.rd_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b2b_extra: got unexpected d=%h want none", bus.rd_data_o);
        end else begin
          exp_v = exp_q.pop_front();
          got++;
          checks++; if (bus.rd_data_o !== exp_v) begin errors++; $display("FAIL b2b_data: got %h want %h", bus.rd_data_o, exp_v); end
        end
      end
    end
    bus.rd_valid_i = 1'b0;
    checks++; if (got !== 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", got); end
    exp_q.delete();
  endtask

  task automatic test_parity();
    logic v, p, e;
    logic [W-1:0] d;
    access(1'b1, 9'd5, 8'h5A, 8'hFF, 1'b0, '0, v, d, p, e);
    access(1'b1, 9'd6, 8'h5A, 8'hFF, 1'b0, '0, v, d, p, e);
`ifdef RAM_PARITY_EN
    dut.mem[5][W] = ~dut.mem[5][W];
    access(1'b0, '0, '0, '0, 1'b1, 9'd5, v, d, p, e);
    checks++; if (v !== 1'b1 || p !== 1'b1) begin errors++; $display("FAIL parity_flag: got v=%b perr=%b want 1 1", v, p); end
    access(1'b0, '0, '0, '0, 1'b1, 9'd6, v, d, p, e);
    checks++; if (v !== 1'b1 || p !== 1'b0) begin errors++; $display("FAIL parity_clean: got v=%b perr=%b want 1 0", v, p); end
`else
    access(1'b0, '0, '0, '0, 1'b1, 9'd5, v, d, p, e);
    checks++; if (v !== 1'b1 || p !== 1'b0) begin errors++; $display("FAIL perr_tied_low: got v=%b perr=%b want 1 0", v, p); end
`endif
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL parity_data: got %h want 5a", d); end
  endtask

  task automatic test_reset_mid_sweep();
    int cycles;
    int viol;
    int rdv;
    logic v, p, e;
    logic [W-1:0] d;
    idle_inputs();
    reset_ni = 1'b0;
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    repeat (100) @(posedge clk_i);
    #1;
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL mid_sweep_busy: got %b want 1", bus.busy_o); end
    reset_ni = 1'b0;
    #1;
    checks++; if (bus.state_dbg !== 1'b0 || bus.busy_o !== 1'b1) begin errors++; $display("FAIL mid_reset_state: got st=%b busy=%b want 0 1", bus.state_dbg, bus.busy_o); end
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = 9'd3;
    bus.wr_data_i  = 8'h77;
    bus.wr_mask_i  = 8'hFF;
    bus.rd_valid_i = 1'b1;
    bus.rd_addr_i  = 9'd3;
    cycles = 0;
    viol = 0;
    rdv = 0;
    do begin
      @(posedge clk_i); #1;
      cycles++;
      if (bus.busy_o && (bus.wr_ready_o || bus.rd_ready_o)) viol++;
      if (bus.rd_valid_o) rdv++;
    end while (bus.busy_o && cycles < MAX_WAIT);
    idle_inputs();
    repeat (2) begin
      @(posedge clk_i); #1;
      if (bus.rd_valid_o) rdv++;
    end
    checks++; if (cycles !== DEPTH) begin errors++; $display("FAIL restart_sweep_length: got %0d want %0d", cycles, DEPTH); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL restart_ready_low: got %0d violations want 0", viol); end
    checks++; if (rdv !== 0) begin errors++; $display("FAIL busy_read_dropped: got %0d responses want 0", rdv); end
    access(1'b0, '0, '0, '0, 1'b1, 9'd3, v, d, p, e);
    checks++; if (v !== 1'b1 || d !== 8'h00) begin errors++; $display("FAIL busy_write_dropped: got v=%b d=%h want v=1 d=00", v, d); end
    access(1'b0, '0, '0, '0, 1'b1, 9'd10, v, d, p, e);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL restart_cleared: got %h want 00", d); end
  endtask

  // Test sequence and final report
  initial begin
    reset_ni = 1'b0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_mask();
    test_collision();
    test_independent();
    test_back_to_back();
    test_parity();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
